// File: rtl/calc1_pkg.sv
// Shared definitions for the calc1 request driver: command and response
// encodings, the driver FSM state type and the datapath widths.
package calc1_pkg;

  localparam int DATA_W = 32;
  localparam int CMD_W  = 4;
  localparam int RESP_W = 2;

  typedef enum logic [CMD_W-1:0] {
    CMD_NOP = 4'd0,
    CMD_ADD = 4'd1,
    CMD_SUB = 4'd2,
    CMD_SHL = 4'd5,
    CMD_SHR = 4'd6
  } cmd_e;

  typedef enum logic [RESP_W-1:0] {
    RESP_NONE    = 2'd0,
    RESP_OK      = 2'd1,
    RESP_OVF     = 2'd2,
    RESP_INVALID = 2'd3
  } resp_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    SEND_CMD  = 3'd1,
    SEND_OP2  = 3'd2,
    WAIT_RESP = 3'd3,
    DONE      = 3'd4
  } state_e;

  // A no-op command completes locally and never reaches calc1.
  function automatic logic is_nop(input logic [0:CMD_W-1] cmd);
    return cmd == CMD_NOP;
  endfunction

endpackage

// File: rtl/calc1_timeout_cnt.sv
// Response watchdog for the calc1 request driver. Counts WAIT_RESP cycles
// and flags the cycle in which the TIMEOUT_CYCLES-th wait cycle elapses.
// Only instantiated when CALC1_DRV_TIMEOUT_EN is defined.
module calc1_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic c_clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [9:0] count;

  // Clears on the cycle before WAIT_RESP is entered, counts while waiting.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 10'd1;
    end
  end

  // count holds the number of wait cycles already elapsed, so this fires in
  // the TIMEOUT_CYCLES-th wait cycle.
  assign expired = enable && (count == 10'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/calc1_req_driver.sv
// calc1 request driver: accepts one host operation, sends command+op1 then
// op2 to a calc1 port, waits for the response and hands it back to the host
// through a valid/ready result handshake.
// Optional feature macro: CALC1_DRV_TIMEOUT_EN enables the response watchdog
// (abort after TIMEOUT_CYCLES wait cycles with rsp_timeout=1).
module calc1_req_driver
  import calc1_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic              host_valid,
  output logic              host_ready,
  input  logic [0:CMD_W-1]  host_cmd,
  input  logic [0:DATA_W-1] host_op1,
  input  logic [0:DATA_W-1] host_op2,
  output logic [0:CMD_W-1]  req_cmd_out,
  output logic [0:DATA_W-1] req_data_out,
  input  logic [0:RESP_W-1] out_resp_in,
  input  logic [0:DATA_W-1] out_data_in,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [0:RESP_W-1] rsp_resp,
  output logic [0:DATA_W-1] rsp_data,
  output logic              rsp_timeout
);

  if (TIMEOUT_CYCLES < 4 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
    $error("calc1_req_driver: TIMEOUT_CYCLES must be within 4..1023");
  end

  state_e state, state_next;

  logic [0:CMD_W-1]  cmd_p0;
  logic [0:DATA_W-1] op1_p0;
  logic [0:DATA_W-1] op2_p0;

  logic accept;
  logic nop_accept;
  logic resp_hit;
  logic timeout_hit;

  assign accept     = (state == IDLE) && host_valid;
  assign nop_accept = accept && is_nop(host_cmd);
  assign resp_hit   = (state == WAIT_RESP) && (out_resp_in != '0);

`ifdef CALC1_DRV_TIMEOUT_EN
  logic expired;

  calc1_timeout_cnt #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .c_clk  (c_clk),
    .reset  (reset),
    .clear  (state == SEND_OP2),
    .enable (state == WAIT_RESP),
    .expired(expired)
  );

  // A response in the expiry cycle wins over the timeout.
  assign timeout_hit = expired && !resp_hit;

  // Timeout flag is rewritten on every entry to DONE.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rsp_timeout <= 1'b0;
    end else if (nop_accept || resp_hit) begin
      rsp_timeout <= 1'b0;
    end else if (timeout_hit) begin
      rsp_timeout <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rsp_timeout = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a no-op goes straight to DONE without touching calc1.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept) state_next = nop_accept ? DONE : SEND_CMD;
      SEND_CMD:  state_next = SEND_OP2;
      SEND_OP2:  state_next = WAIT_RESP;
      WAIT_RESP: if (resp_hit || timeout_hit) state_next = DONE;
      DONE:      if (rsp_ready) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Stage p0: operation captured at the accept edge, held until the next one.
  always_ff @(posedge c_clk) begin
    if (accept) begin
      cmd_p0 <= host_cmd;
      op1_p0 <= host_op1;
      op2_p0 <= host_op2;
    end
  end

  // Result registers, held stable through DONE while the host stalls.
  always_ff @(posedge c_clk or negedge reset) begin
    if (!reset) begin
      rsp_resp <= '0;
      rsp_data <= '0;
    end else if (nop_accept || timeout_hit) begin
      rsp_resp <= '0;
      rsp_data <= '0;
    end else if (resp_hit) begin
      rsp_resp <= out_resp_in;
      rsp_data <= out_data_in;
    end
  end

  // calc1 request bus is only driven in the two send states.
  always_comb begin
    req_cmd_out  = '0;
    req_data_out = '0;
    case (state)
      SEND_CMD: begin
        req_cmd_out  = cmd_p0;
        req_data_out = op1_p0;
      end
      SEND_OP2: req_data_out = op2_p0;
      default: ;
    endcase
  end

  assign host_ready = (state == IDLE) && reset;
  assign rsp_valid  = (state == DONE);

endmodule
